// File: rtl/ucsbece154b_icache_if.sv
// ============================================================================
//  Module      : ucsbece154b_icache_if
//  Description : Fetch-side and refill-side signal bundle for the instruction
//                cache. The slave modport is the cache; the master modport is
//                the core plus instruction memory that surround it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ucsbece154b_icache_if;
    logic        ReadEnable;
    logic [31:0] ReadAddress;
    logic        Misprediction;
    logic [31:0] Instruction;
    logic        Ready;
    logic        Busy;
    logic        PCUpdate;
    logic        MemReadRequest;
    logic [31:0] MemReadAddress;
    logic [31:0] MemDataIn;
    logic        MemDataReady;

    modport slave (
        input  ReadEnable, ReadAddress, Misprediction, MemDataIn, MemDataReady,
        output Instruction, Ready, Busy, PCUpdate, MemReadRequest, MemReadAddress
    );

    modport master (
        output ReadEnable, ReadAddress, Misprediction, MemDataIn, MemDataReady,
        input  Instruction, Ready, Busy, PCUpdate, MemReadRequest, MemReadAddress
    );
endinterface

`default_nettype wire

// File: rtl/ucsbece154b_icache.sv
// ============================================================================
//  Module      : ucsbece154b_icache
//  Description : Set-associative read-only instruction cache with round-robin
//                replacement and in-order block refill. Hits return one cycle
//                after the request; misses run IDLE -> REQ -> FILL -> DONE.
//                Optional macro ICACHE_EARLY_RESTART_EN delivers the requested
//                word as soon as its refill beat arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ucsbece154b_icache #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    ucsbece154b_icache_if.slave  bus
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

    state_t             state, state_next;
    logic [29:0]        miss_pc;          // word address of the missing fetch
    logic [WAY_W-1:0]   victim;
    logic [OFF_W-1:0]   beat_cnt;
    logic               mp_flag;
    logic [31:0]        instr_q;
    logic               ready_q;

    logic               valid    [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]   tag_mem  [NUM_SETS][NUM_WAYS];
    logic [31:0]        data_mem [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [WAY_W-1:0]   rr_ptr   [NUM_SETS];

    // Request-side address fields (byte bits are never used)
    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [OFF_W-1:0]   miss_off;
    logic [IDX_W-1:0]   miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic               unused_byte_bits;

    assign req_off  = bus.ReadAddress[2 +: OFF_W];
    assign req_idx  = bus.ReadAddress[2 + OFF_W +: IDX_W];
    assign req_tag  = bus.ReadAddress[31 -: TAG_W];
    assign miss_off = miss_pc[OFF_W-1:0];
    assign miss_idx = miss_pc[OFF_W +: IDX_W];
    assign miss_tag = miss_pc[29 -: TAG_W];
    assign unused_byte_bits = ^bus.ReadAddress[1:0];

    logic beat_fire, last_beat, mp_now;
    assign beat_fire = (state == S_FILL) && bus.MemDataReady;
    assign last_beat = beat_fire && (beat_cnt == OFF_W'(BLOCK_WORDS - 1));
    // A redirect arriving on the same cycle as a beat counts immediately
    assign mp_now    = mp_flag | bus.Misprediction;

`ifndef ICACHE_EARLY_RESTART_EN
    // Requested word at the last beat: either arriving now or already stored
    logic [31:0] req_word;
    assign req_word = (beat_cnt == miss_off) ? bus.MemDataIn
                                             : data_mem[miss_idx][victim][miss_off];
`endif

    // Tag compare across all ways of the addressed set
    logic        hit;
    logic [31:0] hit_word;
    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
                hit      = 1'b1;
                hit_word = data_mem[req_idx][w][req_off];
            end
        end
    end

    // Next-state and combinational outputs
    always_comb begin
        state_next         = state;
        bus.Busy           = 1'b0;
        bus.MemReadRequest = 1'b0;
        bus.MemReadAddress = '0;
        bus.PCUpdate       = 1'b0;
        case (state)
            S_IDLE: if (bus.ReadEnable && !hit) state_next = S_REQ;
            S_REQ: begin
                bus.Busy           = 1'b1;
                bus.MemReadRequest = 1'b1;
                bus.MemReadAddress = {miss_pc[29:OFF_W], {(OFF_W + 2){1'b0}}};
                state_next         = S_FILL;
            end
            S_FILL: begin
                bus.Busy = 1'b1;
                if (last_beat) state_next = S_DONE;
            end
            S_DONE: begin
                bus.PCUpdate = 1'b1;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.Instruction = instr_q;
    assign bus.Ready       = ready_q;

    // State, control registers, valid bits and replacement pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            miss_pc  <= '0;
            victim   <= '0;
            beat_cnt <= '0;
            mp_flag  <= 1'b0;
            instr_q  <= 32'h00000013;
            ready_q  <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) valid[s][w] <= 1'b0;
            end
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (bus.ReadEnable) begin
                        if (hit) begin
                            instr_q <= hit_word;
                            ready_q <= 1'b1;
                        end else begin
                            ready_q  <= 1'b0;
                            miss_pc  <= bus.ReadAddress[31:2];
                            victim   <= rr_ptr[req_idx];
                            beat_cnt <= '0;
                            mp_flag  <= 1'b0;
                        end
                    end
                end
                S_REQ: if (bus.Misprediction) mp_flag <= 1'b1;
                S_FILL: begin
                    if (bus.Misprediction) mp_flag <= 1'b1;
`ifdef ICACHE_EARLY_RESTART_EN
                    ready_q <= 1'b0;
`endif
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + OFF_W'(1);
`ifdef ICACHE_EARLY_RESTART_EN
                        if (beat_cnt == miss_off) begin
                            instr_q <= bus.MemDataIn;
                            ready_q <= ~mp_now;
                        end
`else
                        if (last_beat) begin
                            instr_q <= req_word;
                            ready_q <= ~mp_now;
                        end
`endif
                        if (last_beat) begin
                            valid[miss_idx][victim] <= 1'b1;
                            rr_ptr[miss_idx]        <= victim + WAY_W'(1);
                        end
                    end
                end
`ifdef ICACHE_EARLY_RESTART_EN
                S_DONE: ready_q <= 1'b0;
`endif
                default: ;
            endcase
        end
    end

    // Line storage: data beats and tag written into the victim way
    always_ff @(posedge clk) begin
        if (beat_fire) data_mem[miss_idx][victim][beat_cnt] <= bus.MemDataIn;
        if (last_beat) tag_mem[miss_idx][victim] <= miss_tag;
    end

endmodule

`default_nettype wire
